// File: rtl/time_set_ctrl.sv
// Settable H:M:S timekeeper: three debounced pushbuttons drive a RUN/SET_H/SET_M/SET_S
// mode FSM that either advances time once per TICK_DIV cycles or edits one field.
module time_set_ctrl #(
    parameter int TICK_DIV   = 1000,
    parameter int DEB_CYCLES = 20,
    parameter int BLINK_DIV  = 250
) (
    input  logic       clkout,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [4:0] H,
    output logic [5:0] M,
    output logic [5:0] S,
    output logic [1:0] mode,
    output logic       blink
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int BW = $clog2(BLINK_DIV + 1);

    localparam int BTN_MODE = 0;
    localparam int BTN_UP   = 1;
    localparam int BTN_DOWN = 2;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } mode_e;

    logic [2:0]    btn_raw;
    logic [2:0]    sync1_q, sync2_q;
    logic [2:0]    deb_q, deb_d, deb_prev_q, press_q;
    logic [DW-1:0] deb_cnt_q [3];
    logic [DW-1:0] deb_cnt_d [3];

    mode_e         state_q, state_d;
    logic [4:0]    h_q, h_d;
    logic [5:0]    m_q, m_d, s_q, s_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          blink_q, blink_d;
    logic          mode_p, up_p, dn_p;

    assign btn_raw = {btn_down, btn_up, btn_mode};

    // Debounce: a level change is accepted after DEB_CYCLES consecutive disagreeing samples.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            deb_d[i]     = deb_q[i];
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DW'(DEB_CYCLES - 1))
                    deb_d[i] = sync2_q[i];
                else
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
            end
        end
    end

    assign mode_p = press_q[BTN_MODE];
    assign up_p   = press_q[BTN_UP] & ~press_q[BTN_DOWN] & ~mode_p;
    assign dn_p   = press_q[BTN_DOWN] & ~press_q[BTN_UP] & ~mode_p;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d = state_q;
        h_d     = h_q;
        m_d     = m_q;
        s_d     = s_q;
        tick_d  = tick_q;
        bcnt_d  = bcnt_q;
        blink_d = blink_q;

        if (mode_p) begin
            unique case (state_q)
                RUN:     state_d = SET_H;
                SET_H:   state_d = SET_M;
                SET_M:   state_d = SET_S;
                default: state_d = RUN;
            endcase
        end

        if (state_q == RUN) begin
            bcnt_d  = '0;
            blink_d = 1'b0;
            if (tick_q == TW'(TICK_DIV - 1)) begin
                tick_d = '0;
                if (s_q == 6'd59) begin
                    s_d = '0;
                    if (m_q == 6'd59) begin
                        m_d = '0;
                        h_d = (h_q == 5'd23) ? 5'd0 : h_q + 5'd1;
                    end else begin
                        m_d = m_q + 6'd1;
                    end
                end else begin
                    s_d = s_q + 6'd1;
                end
            end else begin
                tick_d = tick_q + 1'b1;
            end
        end else begin
            tick_d = '0;
            if (bcnt_q == BW'(BLINK_DIV - 1)) begin
                bcnt_d  = '0;
                blink_d = ~blink_q;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
            unique case (state_q)
                SET_H: begin
                    if (up_p) h_d = (h_q == 5'd23) ? 5'd0 : h_q + 5'd1;
                    if (dn_p) h_d = (h_q == 5'd0) ? 5'd23 : h_q - 5'd1;
                end
                SET_M: begin
                    if (up_p) m_d = (m_q == 6'd59) ? 6'd0 : m_q + 6'd1;
                    if (dn_p) m_d = (m_q == 6'd0) ? 6'd59 : m_q - 6'd1;
                end
                default: begin
                    if (up_p) s_d = (s_q == 6'd59) ? 6'd0 : s_q + 6'd1;
                    if (dn_p) s_d = (s_q == 6'd0) ? 6'd59 : s_q - 6'd1;
                end
            endcase
        end

        // Any mode change restarts the blink phase with the field visible.
        if (mode_p) begin
            bcnt_d  = '0;
            blink_d = 1'b0;
        end
    end

    always_ff @(posedge clkout or posedge rst) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            press_q    <= '0;
            for (int i = 0; i < 3; i++) deb_cnt_q[i] <= '0;
            state_q    <= RUN;
            h_q        <= '0;
            m_q        <= '0;
            s_q        <= '0;
            tick_q     <= '0;
            bcnt_q     <= '0;
            blink_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            press_q    <= deb_q & ~deb_prev_q;
            for (int i = 0; i < 3; i++) deb_cnt_q[i] <= deb_cnt_d[i];
            state_q    <= state_d;
            h_q        <= h_d;
            m_q        <= m_d;
            s_q        <= s_d;
            tick_q     <= tick_d;
            bcnt_q     <= bcnt_d;
            blink_q    <= blink_d;
        end
    end

    assign H     = h_q;
    assign M     = m_q;
    assign S     = s_q;
    assign mode  = state_q;
    assign blink = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with TICK_DIV=4, DEB_CYCLES=3, BLINK_DIV=2.
// Inputs change and outputs are sampled on the falling edge of clkout.
module tb_time_set_ctrl;

    logic       clkout = 1'b0;
    logic       rst;
    logic       btn_mode, btn_up, btn_down;
    logic [4:0] H;
    logic [5:0] M, S;
    logic [1:0] mode;
    logic       blink;

    int vectors     = 0;
    int miscompares = 0;
    int bad_range   = 0;

    time_set_ctrl #(
        .TICK_DIV  (4),
        .DEB_CYCLES(3),
        .BLINK_DIV (2)
    ) dut (
        .clkout  (clkout),
        .rst     (rst),
        .btn_mode(btn_mode),
        .btn_up  (btn_up),
        .btn_down(btn_down),
        .H       (H),
        .M       (M),
        .S       (S),
        .mode    (mode),
        .blink   (blink)
    );

    always #5 clkout = ~clkout;

    // Fields must never show 24 or 60, not even for one cycle.
    always @(negedge clkout)
        if (!rst && (H > 5'd23 || M > 6'd59 || S > 6'd59)) bad_range++;

    initial begin
        #200000;
        $display("FAIL watchdog: got no summary, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s);
        check({tag, ".H"}, 32'(H), h);
        check({tag, ".M"}, 32'(M), m);
        check({tag, ".S"}, 32'(S), s);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clkout);
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0:       btn_mode = v;
            1:       btn_up   = v;
            default: btn_down = v;
        endcase
    endtask

    // Clean press: 4 cycles high, then long enough idle for the release to debounce.
    task automatic press(input int b);
        set_btn(b, 1'b1);
        cycles(4);
        set_btn(b, 1'b0);
        cycles(8);
    endtask

    task automatic do_reset;
        rst      = 1'b1;
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        cycles(2);
        rst = 1'b0;
    endtask

    task automatic wait_mode(input string tag, input int exp);
        for (int i = 0; i < 20 && mode !== 2'(exp); i++) @(negedge clkout);
        check(tag, 32'(mode), exp);
    endtask

    initial begin
        rst      = 1'b1;
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        @(negedge clkout);
        check_time("rst", 0, 0, 0);
        check("rst.mode", 32'(mode), 0);
        check("rst.blink", 32'(blink), 0);

        // Free-running count: S steps every 4 cycles, wraps into M at cycle 240.
        rst = 1'b0;
        for (int i = 1; i <= 240; i++) begin
            @(negedge clkout);
            check_time($sformatf("run%0d", i), 0, i / 240, (i / 4) % 60);
        end

        // Reset mid-tick with a mode press in the synchronizer.
        btn_mode = 1'b1;
        cycles(2);
        rst      = 1'b1;
        btn_mode = 1'b0;
        #1;
        check_time("midrst", 0, 0, 0);
        check("midrst.mode", 32'(mode), 0);
        check("midrst.blink", 32'(blink), 0);
        cycles(2);
        rst = 1'b0;
        cycles(10);
        check("postrst.mode", 32'(mode), 0);
        check_time("postrst", 0, 0, 2);

        // Mode sequence and field wrap; preload 23:59:59.
        do_reset;
        press(0);
        check("m.seth", 32'(mode), 1);
        check_time("m.frozen", 0, 0, 1);
        press(2);
        check("h.dn0", 32'(H), 23);
        press(1);
        check("h.up23", 32'(H), 0);
        press(2);
        press(0);
        check("m.setm", 32'(mode), 2);
        press(2);
        check("m.dn0", 32'(M), 59);
        press(0);
        check("m.sets", 32'(mode), 3);
        press(2);
        check("s.dn1", 32'(S), 0);
        press(2);
        check("s.dn0", 32'(S), 59);
        press(1);
        check_time("s.up59", 23, 59, 0);
        press(2);
        check_time("preload", 23, 59, 59);

        // Back to RUN: full rollover 4 cycles after mode reads 0.
        btn_mode = 1'b1;
        cycles(4);
        btn_mode = 1'b0;
        wait_mode("t2.run", 0);
        check_time("t2.e0", 23, 59, 59);
        cycles(3);
        check_time("t2.e3", 23, 59, 59);
        cycles(1);
        check_time("t2.wrap", 0, 0, 0);

        // Blink phase in SET_H, restart on SET_M, cleared on RUN.
        btn_mode = 1'b1;
        cycles(4);
        btn_mode = 1'b0;
        wait_mode("blk.seth", 1);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) cycles(1);
            check($sformatf("blk%0d", i), 32'(blink), (i / 2) % 2);
        end
        check_time("blk.frozen", 0, 0, 1);
        cycles(3);
        btn_mode = 1'b1;
        cycles(4);
        btn_mode = 1'b0;
        wait_mode("blk.setm", 2);
        check("blkm0", 32'(blink), 0);
        cycles(1);
        check("blkm1", 32'(blink), 0);
        cycles(1);
        check("blkm2", 32'(blink), 1);
        cycles(3);
        press(0);
        check("blk.sets", 32'(mode), 3);
        btn_mode = 1'b1;
        cycles(4);
        btn_mode = 1'b0;
        wait_mode("exit.run", 0);
        check("exit.blink", 32'(blink), 0);
        check_time("exit.e0", 0, 0, 1);
        cycles(3);
        check("exit.e3", 32'(S), 1);
        cycles(1);
        check("exit.e4", 32'(S), 2);

        // Glitch rejection, exact press latency, and single increment on long hold.
        do_reset;
        press(0);
        press(0);
        check("d.setm", 32'(mode), 2);
        check_time("d.start", 0, 0, 1);
        btn_up = 1'b1;
        cycles(2);
        btn_up = 1'b0;
        cycles(10);
        check("glitch", 32'(M), 0);
        btn_up = 1'b1;
        cycles(6);
        check("lat.k5", 32'(M), 0);
        cycles(1);
        check("lat.k6", 32'(M), 1);
        cycles(94);
        btn_up = 1'b0;
        cycles(10);
        check("hold100", 32'(M), 1);

        // Same-cycle priority: up+down cancel, mode beats up.
        btn_up   = 1'b1;
        btn_down = 1'b1;
        cycles(4);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        cycles(8);
        check("updn", 32'(M), 1);
        btn_mode = 1'b1;
        btn_up   = 1'b1;
        cycles(4);
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        cycles(8);
        check("modeup.mode", 32'(mode), 3);
        check_time("modeup", 0, 1, 1);

        check("range", 32'(bad_range), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
